// File: rtl/alloc_trace_pkg.sv
// Shared definitions for the allocator trace collector: state encodings,
// width helpers and the timestamp build switch (ALLOC_TRACE_TIMESTAMP_EN).
package alloc_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_FROZEN = 2'd2
  } trace_state_t;

`ifdef ALLOC_TRACE_TIMESTAMP_EN
  localparam bit TIMESTAMP_EN = 1'b1;
`else
  localparam bit TIMESTAMP_EN = 1'b0;
`endif

  // Ceiling log2; log2c(1) = 0.
  function automatic int unsigned log2c(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

  // Source index field width, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned src_num);
    return (src_num < 2) ? 1 : log2c(src_num);
  endfunction

  // FIFO entry width: {src_idx, [timestamp,] trace}.
  function automatic int unsigned entry_width(input int unsigned src_num,
                                              input int unsigned ts_w,
                                              input int unsigned trace_w);
    return idx_width(src_num) + (TIMESTAMP_EN ? ts_w : 0) + trace_w;
  endfunction

endpackage

// File: rtl/trace_rr_arbiter.sv
// Round-robin arbiter for trace sources: one-hot grant plus encoded index,
// search starts one past the last registered winner.
module trace_rr_arbiter
  import alloc_trace_pkg::*;
#(
  parameter int unsigned SRC_NUM = 4,
  parameter int unsigned IDX_W   = 2
)(
  input  logic               clk,
  input  logic               reset,
  input  logic [SRC_NUM-1:0] req,
  input  logic               en,
  output logic [SRC_NUM-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] last_winner;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Pick the first requester after last_winner, wrapping modulo SRC_NUM.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int unsigned off = 1; off <= SRC_NUM; off++) begin
      cand = IDX_W'((32'(last_winner) + off) % SRC_NUM);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Remember the winner only when its word is actually captured.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_winner <= IDX_W'(SRC_NUM - 1);
    end else if (en) begin
      last_winner <= grant_idx;
    end
  end

endmodule

// File: rtl/alloc_trace_collector.sv
// DfD trace collector: merges per-source triggers into one registered
// trigger, captures round-robin winners into an FWFT FIFO under an
// IDLE/ARMED/FROZEN capture FSM. Timestamp field: ALLOC_TRACE_TIMESTAMP_EN.
module alloc_trace_collector
  import alloc_trace_pkg::*;
#(
  parameter int unsigned SRC_NUM = 4,
  parameter int unsigned TRACE_W = 32,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TS_W    = 16,
  parameter int unsigned DROP_W  = 8,
  localparam int unsigned IDX_W   = idx_width(SRC_NUM),
  localparam int unsigned ENTRY_W = entry_width(SRC_NUM, TS_W, TRACE_W),
  localparam int unsigned CNT_W   = log2c(DEPTH) + 1
)(
  input  logic                       clk,
  input  logic                       reset,
  input  logic [SRC_NUM-1:0]         trigger_in,
  input  logic [SRC_NUM*TRACE_W-1:0] trace_in,
  input  logic                       arm,
  input  logic                       disarm,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [ENTRY_W-1:0]         rd_data,
  output logic [CNT_W-1:0]           fifo_count,
  output logic [DROP_W-1:0]          drop_cnt,
  output logic [1:0]                 state,
  output logic                       trigger,
  output logic [TRACE_W-1:0]         trace_signal
);

  localparam int unsigned AW = log2c(DEPTH);

  trace_state_t       state_q, state_d;
  logic [SRC_NUM-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               any_req;
  logic               armed;
  logic               cap_en;
  logic               wr_en;
  logic               pop;
  logic [TRACE_W-1:0] win_trace;
  logic [DROP_W:0]    drop_add;
  logic [DROP_W:0]    drop_sum;
  logic [ENTRY_W-1:0] wr_entry;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic [DROP_W-1:0]  drop_q;

  assign any_req = |trigger_in;
  assign armed   = (state_q == ST_ARMED);
  assign cap_en  = armed && any_req && (count_q != CNT_W'(DEPTH));
  assign wr_en   = cap_en && !arm;
  assign pop     = rd_en && (count_q != '0);

  trace_rr_arbiter #(
    .SRC_NUM (SRC_NUM),
    .IDX_W   (IDX_W)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (trigger_in),
    .en        (wr_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Select the winner's trace word and size the drop increment.
  always_comb begin
    int unsigned n_req;
    win_trace = '0;
    n_req     = 0;
    for (int unsigned i = 0; i < SRC_NUM; i++) begin
      if (grant[i]) win_trace = win_trace | trace_in[i*TRACE_W +: TRACE_W];
      if (trigger_in[i]) n_req = n_req + 1;
    end
    drop_add = '0;
    if (armed && any_req) drop_add = (DROP_W+1)'(cap_en ? n_req - 1 : n_req);
    drop_sum = {1'b0, drop_q} + drop_add;
  end

`ifdef ALLOC_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  // Free-running timestamp while armed; restarted from zero by arm.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_q <= '0;
    end else if (arm) begin
      ts_q <= '0;
    end else if (armed) begin
      ts_q <= ts_q + 1'b1;
    end
  end

  assign wr_entry = {grant_idx, ts_q, win_trace};
`else
  assign wr_entry = {grant_idx, win_trace};
`endif

  // Capture FSM next state; arm overrides everything, including disarm.
  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = ST_ARMED;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_IDLE;
        ST_ARMED: begin
          if (disarm) state_d = ST_IDLE;
          else if (wr_en && !pop && count_q == CNT_W'(DEPTH - 1)) state_d = ST_FROZEN;
        end
        ST_FROZEN: state_d = ST_FROZEN;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Capture FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FIFO pointers and occupancy; arm flushes ahead of any same-cycle read/write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (arm) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; contents are only observable through the valid-gated head.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_entry;
  end

  // Saturating drop counter, cleared by arm.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_q <= '0;
    end else if (arm) begin
      drop_q <= '0;
    end else if (drop_sum[DROP_W]) begin
      drop_q <= '1;
    end else begin
      drop_q <= drop_sum[DROP_W-1:0];
    end
  end

  // Merged trigger and last-winner trace, updated in every state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trigger      <= 1'b0;
      trace_signal <= '0;
    end else begin
      trigger <= any_req;
      if (any_req) trace_signal <= win_trace;
    end
  end

  assign rd_valid   = (count_q != '0);
  assign rd_data    = rd_valid ? mem[rd_ptr] : '0;
  assign fifo_count = count_q;
  assign drop_cnt   = drop_q;
  assign state      = state_q;

endmodule

// File: tb/tb_alloc_trace_collector.sv
// Directed bench for alloc_trace_collector with default parameters.
module tb_alloc_trace_collector;

`ifdef ALLOC_TRACE_TIMESTAMP_EN
  localparam bit TS_ON = 1'b1;
  localparam int EW    = 50;
`else
  localparam bit TS_ON = 1'b0;
  localparam int EW    = 34;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [3:0]     trigger_in;
  logic [127:0]   trace_in;
  logic           arm, disarm, rd_en;
  logic           rd_valid;
  logic [EW-1:0]  rd_data;
  logic [3:0]     fifo_count;
  logic [7:0]     drop_cnt;
  logic [1:0]     state;
  logic           trigger;
  logic [31:0]    trace_signal;

  int checks   = 0;
  int failures = 0;

  logic [15:0] ts_model = '0;
  logic        model_armed = 1'b0;
  logic [15:0] ts_rec [8];
  logic [15:0] ts_b, ts_c;

  alloc_trace_collector dut (
    .clk          (clk),
    .reset        (reset),
    .trigger_in   (trigger_in),
    .trace_in     (trace_in),
    .arm          (arm),
    .disarm       (disarm),
    .rd_en        (rd_en),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .fifo_count   (fifo_count),
    .drop_cnt     (drop_cnt),
    .state        (state),
    .trigger      (trigger),
    .trace_signal (trace_signal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    if (model_armed) ts_model = ts_model + 16'd1;
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [1:0] idx, input logic [15:0] ts,
                                     input logic [31:0] tr);
    return TS_ON ? {14'd0, idx, ts, tr} : {30'd0, idx, tr};
  endfunction

  initial begin
    reset = 1'b0; arm = 1'b0; disarm = 1'b0; rd_en = 1'b0;
    trigger_in = '0; trace_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_trigger", 64'(trigger), 64'd0);
    chk("rst_trace_signal", 64'(trace_signal), 64'd0);
    reset = 1'b1;
    tick();

    // Arm, then all four sources every cycle: source 0 first after reset.
    arm = 1'b1; tick(); arm = 1'b0; ts_model = '0; model_armed = 1'b1;
    chk("arm_state", 64'(state), 64'd1);
    chk("arm_count", 64'(fifo_count), 64'd0);
    trigger_in = 4'hF;
    for (int i = 0; i < 4; i++) trace_in[i*32 +: 32] = 32'h1111_0000 + 32'(i);
    for (int k = 0; k < 4; k++) begin
      ts_rec[k] = ts_model;
      tick();
    end
    trigger_in = '0;
    chk("rr4_count", 64'(fifo_count), 64'd4);
    chk("rr4_drop", 64'(drop_cnt), 64'd12);
    chk("rr4_trigger", 64'(trigger), 64'd1);
    chk("rr4_trace_signal", 64'(trace_signal), 64'h1111_0003);
    for (int k = 0; k < 4; k++) begin
      chk("rr4_entry", 64'(rd_data), mk(2'(k), ts_rec[k], 32'h1111_0000 + 32'(k)));
      rd_en = 1'b1; tick(); rd_en = 1'b0;
    end
    chk("rr4_empty", 64'(rd_valid), 64'd0);
    chk("trig_drop", 64'(trigger), 64'd0);
    chk("trace_hold", 64'(trace_signal), 64'h1111_0003);

    // Arm, three idle cycles, then a single trigger on source 0.
    arm = 1'b1; tick(); arm = 1'b0; ts_model = '0; model_armed = 1'b1;
    repeat (3) tick();
    trigger_in = 4'b0001; trace_in = '0; trace_in[31:0] = 32'hDEAD_BEEF;
    tick();
    trigger_in = '0;
    chk("t1_rd_valid", 64'(rd_valid), 64'd1);
    chk("t1_rd_data", 64'(rd_data), mk(2'd0, 16'd3, 32'hDEAD_BEEF));
    chk("t1_trigger", 64'(trigger), 64'd1);
    chk("t1_count", 64'(fifo_count), 64'd1);

    // Seven more captures from source 2 fill the FIFO and freeze capture.
    for (int k = 0; k < 7; k++) begin
      trigger_in = 4'b0100;
      trace_in[64 +: 32] = 32'hC0DE_0000 + 32'(k);
      ts_rec[k] = ts_model;
      tick();
    end
    model_armed = 1'b0;
    chk("full_count", 64'(fifo_count), 64'd8);
    chk("full_state", 64'(state), 64'd2);
    trace_in[64 +: 32] = 32'hC0DE_00FF;
    tick();
    trigger_in = '0;
    chk("frozen_count", 64'(fifo_count), 64'd8);
    chk("frozen_drop", 64'(drop_cnt), 64'd0);
    chk("frozen_state", 64'(state), 64'd2);
    chk("frozen_head", 64'(rd_data), mk(2'd0, 16'd3, 32'hDEAD_BEEF));
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("frozen_pop_count", 64'(fifo_count), 64'd7);
    chk("frozen_pop_state", 64'(state), 64'd2);
    chk("src2_entry", 64'(rd_data), mk(2'd2, ts_rec[0], 32'hC0DE_0000));

    // Arm beats a same-cycle read and trigger.
    arm = 1'b1; rd_en = 1'b1; trigger_in = 4'b0001;
    tick();
    arm = 1'b0; rd_en = 1'b0; trigger_in = '0; ts_model = '0; model_armed = 1'b1;
    chk("rearm_count", 64'(fifo_count), 64'd0);
    chk("rearm_valid", 64'(rd_valid), 64'd0);
    chk("rearm_state", 64'(state), 64'd1);
    chk("rearm_drop", 64'(drop_cnt), 64'd0);

    // Three entries, then read and write in the same cycle.
    trigger_in = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      trace_in[32 +: 32] = 32'hA000_0001 + 32'(k);
      ts_rec[k] = ts_model;
      tick();
    end
    trigger_in = 4'b0001; trace_in[31:0] = 32'hB000_000B; ts_b = ts_model; rd_en = 1'b1;
    tick();
    trigger_in = '0;
    chk("rw_count", 64'(fifo_count), 64'd3);
    chk("rw_head0", 64'(rd_data), mk(2'd1, ts_rec[1], 32'hA000_0002));
    tick();
    chk("rw_head1", 64'(rd_data), mk(2'd1, ts_rec[2], 32'hA000_0003));
    tick();
    chk("rw_head2", 64'(rd_data), mk(2'd0, ts_b, 32'hB000_000B));
    tick();
    rd_en = 1'b0;
    chk("rw_empty", 64'(rd_valid), 64'd0);

    // Last winner was source 0, so sources 0 and 2 requesting grant source 2.
    trigger_in = 4'b0101; trace_in[64 +: 32] = 32'hC2C2_C2C2; ts_c = ts_model;
    tick();
    trigger_in = '0;
    chk("rr_next_entry", 64'(rd_data), mk(2'd2, ts_c, 32'hC2C2_C2C2));
    chk("rr_next_drop", 64'(drop_cnt), 64'd1);
    chk("rr_next_trace", 64'(trace_signal), 64'hC2C2_C2C2);

    // Disarm keeps the FIFO; IDLE ignores triggers but trigger output follows.
    disarm = 1'b1; tick(); disarm = 1'b0; model_armed = 1'b0;
    chk("disarm_state", 64'(state), 64'd0);
    chk("disarm_count", 64'(fifo_count), 64'd1);
    trigger_in = 4'b0001; tick(); trigger_in = '0;
    chk("idle_count", 64'(fifo_count), 64'd1);
    chk("idle_drop", 64'(drop_cnt), 64'd1);
    chk("idle_trigger", 64'(trigger), 64'd1);
    chk("idle_trace", 64'(trace_signal), 64'hB000_000B);
    arm = 1'b1; disarm = 1'b1; tick(); arm = 1'b0; disarm = 1'b0;
    ts_model = '0; model_armed = 1'b1;
    chk("arm_wins_state", 64'(state), 64'd1);
    chk("arm_wins_count", 64'(fifo_count), 64'd0);

    // Asynchronous reset mid-operation with five entries queued.
    trigger_in = 4'b0001;
    repeat (5) tick();
    chk("pre_reset_count", 64'(fifo_count), 64'd5);
    #2;
    reset = 1'b0;
    #1;
    chk("async_count", 64'(fifo_count), 64'd0);
    chk("async_valid", 64'(rd_valid), 64'd0);
    chk("async_state", 64'(state), 64'd0);
    chk("async_trigger", 64'(trigger), 64'd0);
    trigger_in = '0; model_armed = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("post_reset_state", 64'(state), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
